decode_queue: RTL

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_queue.sv
// Decoded-instruction queue: RV32I decode on push, DEPTH-entry circular buffer, registered head.
// Optional macro RV32M_DECODE_EN enables M-extension decoding (otherwise funct7=0000001 on OP is illegal).
module decode_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [PC_W-1:0]          in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PC_W-1:0]          out_pc,
   output logic [31:0]              out_imm,
   output logic [4:0]               out_rs1,
   output logic [4:0]               out_rs2,
   output logic [4:0]               out_rd,
   output logic [3:0]               out_alu_op,
   output logic [11:0]              out_ctrl,
   output logic                     out_src_imm,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [3:0] ALU_OP_ADD    = 4'd0;
   localparam logic [3:0] ALU_OP_SUB    = 4'd1;
   localparam logic [3:0] ALU_OP_SLL    = 4'd2;
   localparam logic [3:0] ALU_OP_SLT    = 4'd3;
   localparam logic [3:0] ALU_OP_SLTU   = 4'd4;
   localparam logic [3:0] ALU_OP_XOR    = 4'd5;
   localparam logic [3:0] ALU_OP_SRL    = 4'd6;
   localparam logic [3:0] ALU_OP_SRA    = 4'd7;
   localparam logic [3:0] ALU_OP_OR     = 4'd8;
   localparam logic [3:0] ALU_OP_AND    = 4'd9;
   localparam logic [3:0] ALU_OP_MUL    = 4'd10;
   localparam logic [3:0] ALU_OP_MULH   = 4'd11;
   localparam logic [3:0] ALU_OP_MULHSU = 4'd12;
   localparam logic [3:0] ALU_OP_MULHU  = 4'd13;
   localparam logic [3:0] ALU_OP_DIV    = 4'd14;
   localparam logic [3:0] ALU_OP_DIVU   = 4'd15;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [3:0]      alu_op;
      logic [11:0]     ctrl;
      logic            src_imm;
   } entry_t;

   // alt selects SUB (funct3=000) or SRA (funct3=101)
   function automatic logic [3:0] base_alu(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  base_alu = alt ? ALU_OP_SUB : ALU_OP_ADD;
         3'b001:  base_alu = ALU_OP_SLL;
         3'b010:  base_alu = ALU_OP_SLT;
         3'b011:  base_alu = ALU_OP_SLTU;
         3'b100:  base_alu = ALU_OP_XOR;
         3'b101:  base_alu = alt ? ALU_OP_SRA : ALU_OP_SRL;
         3'b110:  base_alu = ALU_OP_OR;
         default: base_alu = ALU_OP_AND;
      endcase
   endfunction

`ifdef RV32M_DECODE_EN
   // REM/REMU share the divider codes; funct3 travels in the raw encoding
   function automatic logic [3:0] m_alu(input logic [2:0] f3);
      case (f3)
         3'b000:  m_alu = ALU_OP_MUL;
         3'b001:  m_alu = ALU_OP_MULH;
         3'b010:  m_alu = ALU_OP_MULHSU;
         3'b011:  m_alu = ALU_OP_MULHU;
         3'b100,
         3'b110:  m_alu = ALU_OP_DIV;
         default: m_alu = ALU_OP_DIVU;
      endcase
   endfunction
`endif

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign i_imm  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign s_imm  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign b_imm  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign u_imm  = {in_instr[31:12], 12'b0};
   assign j_imm  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   logic d_illegal, d_wfi, d_mret, d_ebreak, d_ecall, d_is_m, d_system;
   logic d_jump, d_branch, d_reg_write, d_mem_write, d_mem_read, d_src_imm;
   logic [31:0] d_imm;
   logic [4:0]  d_rs1;
   logic [3:0]  d_alu;

   always_comb begin
      d_illegal   = 1'b0;
      d_wfi       = 1'b0;
      d_mret      = 1'b0;
      d_ebreak    = 1'b0;
      d_ecall     = 1'b0;
      d_is_m      = 1'b0;
      d_system    = 1'b0;
      d_jump      = 1'b0;
      d_branch    = 1'b0;
      d_reg_write = 1'b0;
      d_mem_write = 1'b0;
      d_mem_read  = 1'b0;
      d_src_imm   = 1'b0;
      d_imm       = 32'd0;
      d_rs1       = in_instr[19:15];
      d_alu       = ALU_OP_ADD;
      case (opcode)
         OPC_LUI: begin
            d_imm = u_imm; d_reg_write = 1'b1; d_src_imm = 1'b1; d_rs1 = 5'd0;
         end
         OPC_AUIPC: begin
            d_imm = u_imm; d_reg_write = 1'b1; d_src_imm = 1'b1;
         end
         OPC_JAL: begin
            d_imm = j_imm; d_jump = 1'b1; d_reg_write = 1'b1;
         end
         OPC_JALR: begin
            d_imm = i_imm; d_jump = 1'b1; d_reg_write = 1'b1; d_src_imm = 1'b1;
         end
         OPC_BRANCH: begin
            d_imm = b_imm; d_branch = 1'b1;
            case (funct3[2:1])
               2'b10:   d_alu = ALU_OP_SLT;
               2'b11:   d_alu = ALU_OP_SLTU;
               default: d_alu = ALU_OP_SUB;
            endcase
         end
         OPC_LOAD: begin
            d_imm = i_imm; d_mem_read = 1'b1; d_reg_write = 1'b1; d_src_imm = 1'b1;
            if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) d_illegal = 1'b1;
         end
         OPC_STORE: begin
            d_imm = s_imm; d_mem_write = 1'b1; d_src_imm = 1'b1;
            if (funct3 >= 3'b011) d_illegal = 1'b1;
         end
         OPC_OP_IMM: begin
            d_imm = i_imm; d_reg_write = 1'b1; d_src_imm = 1'b1;
            d_alu = base_alu(funct3, (funct3 == 3'b101) && funct7[5]);
            // shift-amount encodings reserve instr[31:25] except the SRAI selector bit
            if (funct3 == 3'b001 && funct7 != 7'd0) d_illegal = 1'b1;
            if (funct3 == 3'b101 && (funct7 & 7'b1011111) != 7'd0) d_illegal = 1'b1;
         end
         OPC_OP: begin
            d_reg_write = 1'b1;
            if (funct7 == 7'b0000000) begin
               d_alu = base_alu(funct3, 1'b0);
            end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
               d_alu = base_alu(funct3, 1'b1);
            end else if (funct7 == 7'b0000001) begin
`ifdef RV32M_DECODE_EN
               d_is_m = 1'b1;
               d_alu  = m_alu(funct3);
`else
               d_illegal = 1'b1;
`endif
            end else begin
               d_illegal = 1'b1;
            end
         end
         OPC_MISC_MEM: begin
         end
         OPC_SYSTEM: begin
            d_system = 1'b1;
            if (funct3 == 3'b000) begin
               case (in_instr[31:20])
                  12'h000: d_ecall  = 1'b1;
                  12'h001: d_ebreak = 1'b1;
                  12'h302: d_mret   = 1'b1;
                  12'h105: d_wfi    = 1'b1;
                  default: d_illegal = 1'b1;
               endcase
            end else if (funct3 == 3'b100) begin
               d_illegal = 1'b1;
            end else begin
               // CSR access: imm carries the CSR address
               d_imm       = i_imm;
               d_reg_write = (in_instr[11:7] != 5'd0);
            end
         end
         default: d_illegal = 1'b1;
      endcase
      if (d_illegal) begin
         d_reg_write = 1'b0;
         d_mem_read  = 1'b0;
         d_mem_write = 1'b0;
      end
   end

   entry_t new_entry;
   assign new_entry = '{pc: in_pc, imm: d_imm, rs1: d_rs1, rs2: in_instr[24:20],
                        rd: in_instr[11:7], alu_op: d_alu,
                        ctrl: {d_illegal, d_wfi, d_mret, d_ebreak, d_ecall, d_is_m,
                               d_system, d_jump, d_branch, d_reg_write, d_mem_write, d_mem_read},
                        src_imm: d_src_imm};

   // Handshake: a beat transfers on a cycle where valid && ready are both high at the rising edge;
   // in_ready may depend on out_ready (push into a full queue while it pops), never the reverse.
   logic          push, pop;
   logic [AW-1:0] wr_ptr, rd_ptr;
   entry_t        mem [DEPTH];
   entry_t        head;

   assign out_valid = (count != '0);
   assign in_ready  = (count < FULL) || out_ready;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; only occupancy and pointers define what is visible.
   always_ff @(posedge clk) begin
      if (push && !flush && !rst) mem[wr_ptr] <= new_entry;
   end

   assign head        = mem[rd_ptr];
   assign out_pc      = head.pc;
   assign out_imm     = head.imm;
   assign out_rs1     = head.rs1;
   assign out_rs2     = head.rs2;
   assign out_rd      = head.rd;
   assign out_alu_op  = head.alu_op;
   assign out_ctrl    = head.ctrl;
   assign out_src_imm = head.src_imm;

endmodule
